mux16_scan_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 16:1 single-bit mux. It drives the mux select lines s3..s0 through all 16 codes. For each code it samples the mux output y and assembles a 16-bit word, where bit i is the value of a_i. The finished word goes to the consumer over a valid/ready handshake, so the mux acts as a parallel-to-serial-to-parallel scan path.

---
 rtl/mux16_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_mux16_scan_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mux16_scan_ctrl.sv
// rtl/mux16_scan_ctrl.sv - steps a 16:1 mux through every select code and reassembles its inputs into a word
module mux16_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mux_y,
  output logic [3:0]  sel,
  output logic        busy,
  output logic [15:0] data_out,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  if (SETTLE < 1) begin : g_settle_check
    $fatal(1, "mux16_scan_ctrl: SETTLE must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  // Bit 15 never needs storing: it goes straight from mux_y into data_out.
  logic [14:0]      cap, cap_n;
  logic [3:0]       sel_n;
  logic             busy_n;
  logic             valid_n;
  logic [15:0]      data_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cap       <= '0;
      sel       <= 4'd0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= 16'h0000;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cap       <= cap_n;
      sel       <= sel_n;
      busy      <= busy_n;
      out_valid <= valid_n;
      data_out  <= data_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap_n   = cap;
    sel_n   = sel;
    busy_n  = busy;
    valid_n = out_valid;
    data_n  = data_out;

    case (state)
      IDLE: begin
        sel_n   = 4'd0;
        busy_n  = 1'b0;
        valid_n = 1'b0;
        if (start) begin
          state_n = SCAN;
          cnt_n   = '0;
          busy_n  = 1'b1;
        end
      end

      SCAN: begin
        busy_n  = 1'b1;
        valid_n = 1'b0;
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (sel == 4'd15) begin
            state_n = HOLD;
            data_n  = {mux_y, cap};
            valid_n = 1'b1;
            sel_n   = 4'd0;
          end else begin
            cap_n[sel] = mux_y;
            sel_n      = sel + 4'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      HOLD: begin
        sel_n   = 4'd0;
        busy_n  = 1'b1;
        valid_n = 1'b1;
        if (out_ready) begin
          valid_n = 1'b0;
          // A start alongside the accept chains the next scan with no idle gap.
          if (start) begin
            state_n = SCAN;
            cnt_n   = '0;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        sel_n   = 4'd0;
        busy_n  = 1'b0;
        valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// tb/tb_mux16_scan_ctrl.sv - directed bench for mux16_scan_ctrl with SETTLE=1 and SETTLE=3 instances
module tb_mux16_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start1, ready1;
  logic [15:0] pat1;
  logic        y1;
  logic [3:0]  sel1;
  logic        busy1, valid1;
  logic [15:0] data1;

  logic        start3, ready3;
  logic [15:0] pat3;
  logic        y3;
  logic [3:0]  sel3;
  logic        busy3, valid3;
  logic [15:0] data3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign y1 = pat1[sel1];
  assign y3 = pat3[sel3];

  mux16_scan_ctrl #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mux_y(y1), .sel(sel1),
    .busy(busy1), .data_out(data1), .out_valid(valid1), .out_ready(ready1)
  );

  mux16_scan_ctrl #(.SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mux_y(y3), .sel(sel3),
    .busy(busy3), .data_out(data3), .out_valid(valid3), .out_ready(ready3)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic [3:0] s, input logic b,
                        input logic v, input logic [15:0] d);
    check({tag, "_sel"}, {12'h0, sel1}, {12'h0, s});
    check({tag, "_busy"}, {15'h0, busy1}, {15'h0, b});
    check({tag, "_valid"}, {15'h0, valid1}, {15'h0, v});
    check({tag, "_data"}, data1, d);
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b1; ready1 = 1'b1; pat1 = 16'hAAAA;
    start3 = 1'b1; ready3 = 1'b1; pat3 = 16'h8001;

    // 1: reset holds everything idle even with start asserted
    for (int i = 0; i < 3; i++) begin
      step();
      check1("rst", 4'd0, 1'b0, 1'b0, 16'h0000);
      check("rst3_busy", {15'h0, busy3}, 16'h0);
      check("rst3_data", data3, 16'h0000);
    end
    start3 = 1'b0;

    // 2: single scan, SETTLE=1, consumer ready
    rst_n = 1'b1; start1 = 1'b1; ready1 = 1'b1; pat1 = 16'hAAAA;
    step();
    start1 = 1'b0;
    check1("t2_acc", 4'd0, 1'b1, 1'b0, 16'h0000);
    for (int i = 1; i < 16; i++) begin
      step();
      check("t2_sel", {12'h0, sel1}, 16'(i));
      check("t2_novalid", {15'h0, valid1}, 16'h0);
    end
    step();
    check1("t2_done", 4'd0, 1'b1, 1'b1, 16'hAAAA);
    step();
    check1("t2_idle", 4'd0, 1'b0, 1'b0, 16'hAAAA);

    // 3: backpressure holds the word; start ignored in HOLD without ready
    ready1 = 1'b0; start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int i = 1; i < 16; i++) step();
    step();
    check1("t3_hold0", 4'd0, 1'b1, 1'b1, 16'hAAAA);
    for (int i = 0; i < 5; i++) begin
      start1 = i[0];
      step();
      check1("t3_hold", 4'd0, 1'b1, 1'b1, 16'hAAAA);
    end
    start1 = 1'b0; ready1 = 1'b1;
    step();
    check1("t3_idle", 4'd0, 1'b0, 1'b0, 16'hAAAA);

    // 4: back-to-back scan straight from HOLD; mid-scan start ignored
    ready1 = 1'b0; start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int i = 1; i < 16; i++) step();
    step();
    check1("t4_hold", 4'd0, 1'b1, 1'b1, 16'hAAAA);
    pat1 = 16'h1234; start1 = 1'b1; ready1 = 1'b1;
    step();
    start1 = 1'b0;
    check("t4_b2b_busy", {15'h0, busy1}, 16'h1);
    check("t4_b2b_valid", {15'h0, valid1}, 16'h0);
    check("t4_b2b_sel", {12'h0, sel1}, 16'h0);
    for (int i = 1; i < 16; i++) begin
      start1 = (i == 8);
      step();
      check("t4_sel", {12'h0, sel1}, 16'(i));
    end
    start1 = 1'b0;
    step();
    check1("t4_done", 4'd0, 1'b1, 1'b1, 16'h1234);
    step();
    check1("t4_idle", 4'd0, 1'b0, 1'b0, 16'h1234);

    // 5: SETTLE=3, each code held three cycles, valid at edge 48
    start3 = 1'b1; ready3 = 1'b1;
    step();
    start3 = 1'b0;
    check("t5_sel0", {12'h0, sel3}, 16'h0);
    for (int e = 1; e < 48; e++) begin
      step();
      check("t5_sel", {12'h0, sel3}, 16'(e / 3));
      check("t5_novalid", {15'h0, valid3}, 16'h0);
    end
    step();
    check("t5_valid", {15'h0, valid3}, 16'h1);
    check("t5_data", data3, 16'h8001);
    step();
    check("t5_idle_busy", {15'h0, busy3}, 16'h0);

    // 6: reset mid-scan at sel=7, then a clean rescan
    pat1 = 16'hFFFF; start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    check("t6_sel7", {12'h0, sel1}, 16'h7);
    rst_n = 1'b0;
    step();
    check1("t6_rst", 4'd0, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b1; pat1 = 16'h5A5A; start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int i = 1; i < 16; i++) step();
    step();
    check1("t6_done", 4'd0, 1'b1, 1'b1, 16'h5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
